// File: rtl/risc_imem_responder.sv
// Instruction-memory responder: registered 1-cycle reads for the fetch unit in RUN,
// and a handshaked loader port that fills the array (with per-word valid bits) in LOAD.
module risc_imem_responder #(
   parameter int unsigned       ADDR_W = 5,
   parameter int unsigned       DATA_W = 13,
   parameter logic [DATA_W-1:0] NOP    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instruction,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic              ld_last,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              ld_done,
   output logic              loading,
   output logic [ADDR_W:0]   ld_count
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DEPTH-1:0]    valid;
   logic [ADDR_W-1:0]   wptr, wptr_d;
   logic [DATA_W-1:0]   instruction_d;
   logic                ld_ready_d;
   logic                ld_done_d;
   logic                loading_d;
   logic [CNT_W-1:0]    ld_count_d;
   logic                clear_valid;
   logic                wr_en;

   // State, output and bookkeeping registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         instruction <= NOP;
         ld_ready    <= 1'b0;
         ld_done     <= 1'b0;
         loading     <= 1'b0;
         ld_count    <= '0;
         wptr        <= '0;
         valid       <= '0;
      end else begin
         state       <= state_d;
         instruction <= instruction_d;
         ld_ready    <= ld_ready_d;
         ld_done     <= ld_done_d;
         loading     <= loading_d;
         ld_count    <= ld_count_d;
         wptr        <= wptr_d;
         if (clear_valid) begin
            valid <= '0;
         end else if (wr_en) begin
            valid[wptr] <= 1'b1;
         end
      end
   end

   // Program array; contents intentionally survive reset
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem[wptr] <= ld_data;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state;
      instruction_d = NOP;
      ld_ready_d    = 1'b0;
      ld_done_d     = 1'b0;
      loading_d     = 1'b0;
      ld_count_d    = ld_count;
      wptr_d        = wptr;
      clear_valid   = 1'b0;
      wr_en         = 1'b0;

      unique case (state)
         IDLE: begin
            if (ld_start) begin
               state_d     = LOAD;
               ld_ready_d  = 1'b1;
               loading_d   = 1'b1;
               ld_count_d  = '0;
               wptr_d      = '0;
               clear_valid = 1'b1;
            end
         end
         LOAD: begin
            ld_ready_d = 1'b1;
            loading_d  = 1'b1;
            if (ld_valid && ld_ready) begin
               wr_en      = 1'b1;
               wptr_d     = wptr + ADDR_W'(1);
               ld_count_d = ld_count + CNT_W'(1);
               // A full array ends the load regardless of ld_last
               if (ld_last || (wptr == ADDR_W'(DEPTH - 1))) begin
                  state_d    = RUN;
                  ld_ready_d = 1'b0;
                  loading_d  = 1'b0;
                  ld_done_d  = 1'b1;
               end
            end
         end
         RUN: begin
            if (ld_start) begin
               state_d     = LOAD;
               ld_ready_d  = 1'b1;
               loading_d   = 1'b1;
               ld_count_d  = '0;
               wptr_d      = '0;
               clear_valid = 1'b1;
            end else begin
               instruction_d = valid[pc] ? mem[pc] : NOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_risc_imem_responder.sv
// Directed bench for risc_imem_responder: table-driven fetch reads plus
// hand-written load, reload and reset-abort sequences.
module tb_risc_imem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  pc;
   logic [12:0] instruction;
   logic        ld_start;
   logic        ld_valid;
   logic        ld_last;
   logic [12:0] ld_data;
   logic        ld_ready;
   logic        ld_done;
   logic        loading;
   logic [5:0]  ld_count;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;

   typedef struct packed {
      logic [4:0]  pc;
      logic [12:0] exp;
   } rd_vec_t;

   rd_vec_t full_tab[$];
   rd_vec_t wrap_tab[$];
   rd_vec_t short_tab[$];
   rd_vec_t reload_tab[$];

   risc_imem_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .instruction (instruction),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_last     (ld_last),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .ld_done     (ld_done),
      .loading     (loading),
      .ld_count    (ld_count)
   );

   always #5 clk = ~clk;

   // One clock edge, then sample 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
      if (ld_done) done_cnt++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_reads(input string name, input rd_vec_t tab[$]);
      for (int i = 0; i < tab.size(); i++) begin
         pc = tab[i].pc;
         step();
         chk($sformatf("%s[pc=%0d]", name, tab[i].pc), 32'(instruction), 32'(tab[i].exp));
      end
   endtask

   task automatic load_word(input logic [12:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   initial begin
      int d0;
      // Expected read tables
      for (int i = 0; i < 32; i++) full_tab.push_back('{pc: 5'(i), exp: 13'(13'h1000 + i)});
      wrap_tab.push_back('{pc: 5'd30, exp: 13'h101E});
      wrap_tab.push_back('{pc: 5'd31, exp: 13'h101F});
      wrap_tab.push_back('{pc: 5'd0,  exp: 13'h1000});
      wrap_tab.push_back('{pc: 5'd1,  exp: 13'h1001});
      reload_tab.push_back('{pc: 5'd0, exp: 13'h1FFF});
      reload_tab.push_back('{pc: 5'd1, exp: 13'h0000});
      reload_tab.push_back('{pc: 5'd5, exp: 13'h0000});
      short_tab.push_back('{pc: 5'd0,  exp: 13'h0AAA});
      short_tab.push_back('{pc: 5'd1,  exp: 13'h0BBB});
      short_tab.push_back('{pc: 5'd2,  exp: 13'h0CCC});
      short_tab.push_back('{pc: 5'd3,  exp: 13'h0000});
      short_tab.push_back('{pc: 5'd31, exp: 13'h0000});

      // Reset with ld_start held high
      rst_n = 1'b0; ld_start = 1'b1; ld_valid = 1'b0; ld_last = 1'b0;
      ld_data = '0; pc = '0;
      step(); step();
      chk("rst_instr", 32'(instruction), 32'h0);
      chk("rst_ready", 32'(ld_ready), 32'h0);
      chk("rst_count", 32'(ld_count), 32'h0);
      chk("rst_loading", 32'(loading), 32'h0);
      chk("rst_done", 32'(ld_done), 32'h0);
      rst_n = 1'b1; ld_start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         pc = 5'(i);
         step();
         chk("idle_nop", 32'(instruction), 32'h0);
      end

      // Full load of 32 words, ld_last never set
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      chk("full_loading", 32'(loading), 32'h1);
      chk("full_ready", 32'(ld_ready), 32'h1);
      chk("full_cnt0", 32'(ld_count), 32'h0);
      d0 = done_cnt;
      for (int i = 0; i < 32; i++) begin
         load_word(13'(13'h1000 + i), 1'b0);
         if (i < 31) chk("full_early_done", 32'(ld_done), 32'h0);
      end
      chk("full_done", 32'(ld_done), 32'h1);
      chk("full_count", 32'(ld_count), 32'd32);
      chk("full_ready_off", 32'(ld_ready), 32'h0);
      chk("full_loading_off", 32'(loading), 32'h0);
      step();
      chk("full_done_pulse", 32'(ld_done), 32'h0);
      chk("full_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("full_count_hold", 32'(ld_count), 32'd32);
      run_reads("full_rd", full_tab);
      run_reads("wrap_rd", wrap_tab);

      // Reload from RUN with a single word
      ld_start = 1'b1; pc = 5'd0;
      step();
      ld_start = 1'b0;
      chk("reload_nop", 32'(instruction), 32'h0);
      chk("reload_loading", 32'(loading), 32'h1);
      chk("reload_cnt0", 32'(ld_count), 32'h0);
      load_word(13'h1FFF, 1'b1);
      chk("reload_done", 32'(ld_done), 32'h1);
      chk("reload_count", 32'(ld_count), 32'd1);
      run_reads("reload_rd", reload_tab);

      // Short load with gaps; ld_start during a gap is ignored
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      load_word(13'h0AAA, 1'b0);
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      step();
      chk("gap_count", 32'(ld_count), 32'd1);
      chk("gap_loading", 32'(loading), 32'h1);
      chk("gap_done", 32'(ld_done), 32'h0);
      load_word(13'h0BBB, 1'b0);
      step(); step();
      load_word(13'h0CCC, 1'b1);
      chk("short_done", 32'(ld_done), 32'h1);
      chk("short_count", 32'(ld_count), 32'd3);
      run_reads("short_rd", short_tab);

      // Reset after 5 of 10 words aborts the load
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 5; i++) load_word(13'(13'h0300 + i), 1'b0);
      chk("abort_count5", 32'(ld_count), 32'd5);
      rst_n = 1'b0; ld_valid = 1'b1; ld_data = 13'h0305;
      step();
      rst_n = 1'b1;
      chk("abort_loading", 32'(loading), 32'h0);
      chk("abort_ready", 32'(ld_ready), 32'h0);
      chk("abort_instr", 32'(instruction), 32'h0);
      chk("abort_count", 32'(ld_count), 32'h0);
      ld_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc = 5'(i);
         step();
         chk("abort_idle_instr", 32'(instruction), 32'h0);
         chk("abort_idle_loading", 32'(loading), 32'h0);
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      load_word(13'h0777, 1'b1);
      chk("restart_done", 32'(ld_done), 32'h1);
      pc = 5'd0;
      step();
      chk("restart_rd", 32'(instruction), 32'h0777);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
